// File: rtl/usbf_wb_arb_pkg.sv
// Shared types and constants for the USB function Wishbone arbiter.
// USBF_UFC_HADR normally comes from usbf_defines. The fallback below
// keeps this slice self-contained when that file is not compiled first.
`ifndef USBF_UFC_HADR
`define USBF_UFC_HADR 17
`endif

package usbf_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int DATA_W   = 32;
  localparam int DEF_AW   = `USBF_UFC_HADR + 1;
  localparam int TO_CNT_W = 16;

endpackage

// File: rtl/usbf_rr_pick.sv
// Combinational round-robin picker: grants the first set request at or
// after i_ptr, wrapping from N-1 back to 0. Also used by the DMA service
// engine, so it carries no state of its own.
module usbf_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [PW-1:0]  w_off;
  logic [PW:0]    w_sum;
  logic [PW:0]    w_wrap;

  // Rotate requests so that bit 0 of w_rot corresponds to requester i_ptr.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  // Offset of the lowest set bit of the rotated vector.
  always_comb begin
    // NOTE: w_off gets a default before the loop so an all-zero request vector
    // cannot leave it unassigned and infer a latch.
    w_off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = PW'(j);
    end
  end

  // Undo the rotation: winner = (ptr + offset) mod N.
  assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
  assign w_wrap  = w_sum - (PW+1)'(N);
  assign o_idx   = (w_sum >= (PW+1)'(N)) ? w_wrap[PW-1:0] : w_sum[PW-1:0];
  assign o_valid = |i_req;
  assign o_gnt   = o_valid ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/usbf_wb_arbiter.sv
// Round-robin arbiter sharing the usbf Wishbone slave port between NREQ
// requesters. One single-beat classic Wishbone cycle at a time, followed
// by a mandatory idle bus cycle. Interrupt/suspend pins pass straight
// through outside this block.
// Optional feature: define USBF_WB_TIMEOUT_EN to abort a bus cycle that
// sees no ack within TO_CYCLES clocks (done_o with err_o=1). Without it the
// bus waits for ack indefinitely and err_o is tied low.
module usbf_wb_arbiter
  import usbf_wb_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int AW        = DEF_AW,
  parameter int TO_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0]        req_we_i,
  input  logic [NREQ*AW-1:0]     req_addr_i,
  input  logic [NREQ*DATA_W-1:0] req_wdata_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [NREQ-1:0]        done_o,
  output logic                   err_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic [AW-1:0]          wb_addr_o,
  output logic [DATA_W-1:0]      wb_data_o,
  input  logic [DATA_W-1:0]      wb_data_i,
  output logic                   wb_we_o,
  output logic                   wb_stb_o,
  output logic                   wb_cyc_o,
  input  logic                   wb_ack_i
);

  localparam int PW = $clog2(NREQ);

  // Reject configurations the pointer and counter widths cannot represent.
  if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 2 || TO_CYCLES > 65536) begin : g_bad_cfg
    $error("usbf_wb_arbiter: unsupported NREQ/TO_CYCLES");
  end

  // Picker outputs and the winner's transaction fields.
  logic [NREQ-1:0]   w_pick_gnt;
  logic [PW-1:0]     w_pick_idx;
  logic              w_pick_valid;
  logic [AW-1:0]     w_pick_addr;
  logic [DATA_W-1:0] w_pick_wdata;
  logic              w_pick_we;
  logic [PW-1:0]     w_next_ptr;

  // Registered state; every output is driven straight from a register.
  arb_state_t        r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_gidx;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic [DATA_W-1:0] r_rdata;
  logic [AW-1:0]     r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_cyc;

`ifdef USBF_WB_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TO_CYCLES - 1);
  logic [TO_CNT_W-1:0] r_to_cnt;
  logic                r_err;
`endif

  usbf_rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_pick_addr  = req_addr_i[int'(w_pick_idx)*AW +: AW];
  assign w_pick_wdata = req_wdata_i[int'(w_pick_idx)*DATA_W +: DATA_W];
  assign w_pick_we    = req_we_i[w_pick_idx];

  // Pointer moves to the requester after the one just served.
  assign w_next_ptr = (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;

  // Arbitration FSM: IDLE picks a winner, BUS runs the Wishbone beat,
  // DONE is the idle gap the usbf slave needs between cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gidx   <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_rdata  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_cyc    <= 1'b0;
`ifdef USBF_WB_TIMEOUT_EN
      r_to_cnt <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout so every register updates
      // from pre-edge values regardless of statement order.
      r_done <= '0;
`ifdef USBF_WB_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_gnt    <= w_pick_gnt;
            r_gidx   <= w_pick_idx;
            r_addr   <= w_pick_addr;
            r_wdata  <= w_pick_wdata;
            r_we     <= w_pick_we;
            r_cyc    <= 1'b1;
`ifdef USBF_WB_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
            r_state  <= BUS;
          end
        end
        BUS: begin
          // A dropped req_i here is ignored; the beat always completes.
          if (wb_ack_i) begin
            if (!r_we) r_rdata <= wb_data_i;
            r_cyc   <= 1'b0;
            r_gnt   <= '0;
            r_done  <= r_gnt;
            r_ptr   <= w_next_ptr;
            r_state <= DONE;
          end
`ifdef USBF_WB_TIMEOUT_EN
          // Ack in the expiry cycle takes the branch above, so ack wins.
          else if (r_to_cnt == TO_LAST) begin
            r_cyc   <= 1'b0;
            r_gnt   <= '0;
            r_done  <= r_gnt;
            r_err   <= 1'b1;
            r_ptr   <= w_next_ptr;
            r_state <= DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o     = r_gnt;
  assign done_o    = r_done;
  assign rdata_o   = r_rdata;
  assign wb_addr_o = r_addr;
  assign wb_data_o = r_wdata;
  assign wb_we_o   = r_we;
  assign wb_stb_o  = r_cyc;
  assign wb_cyc_o  = r_cyc;
`ifdef USBF_WB_TIMEOUT_EN
  assign err_o     = r_err;
`else
  assign err_o     = 1'b0;
`endif

endmodule
